// File: rtl/pincfg_mux_pkg.sv
// pincfg_pkg: shared constants for the pin configuration mux.
//   Register word addresses and STATUS bit positions used by the
//   bus decode in pincfg_mux and by anything that talks to it.
package pincfg_pkg;
  localparam logic [3:0] ADR_POLARITY = 4'd0;
  localparam logic [3:0] ADR_SELECT   = 4'd1;
  localparam logic [3:0] ADR_SDMASK   = 4'd2;
  localparam logic [3:0] ADR_STATUS   = 4'd3;
  localparam logic [3:0] ADR_FILTER   = 4'd4;
  localparam logic [3:0] ADR_EVCOUNT  = 4'd5;

  localparam int ST_ACTIVE = 0;  // sticky shutdown state, write 1 to clear
  localparam int ST_SYNC   = 1;  // synchronised shutdown input, read-only
endpackage

// File: rtl/pincfg_mux_if.sv
// pincfg_mux_if: Wishbone-style register bus between a host and pincfg_mux.
//   wb_cyc_i/wb_stb_i/wb_we_i  request qualifiers
//   wb_adr_i                   register word address
//   wb_dat_i / wb_dat_o        write / registered read data
//   wb_ack_o                   registered single-cycle acknowledge
interface pincfg_mux_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/pincfg_mux_shutdown_filter.sv
// pincfg_shutdown_filter: synchroniser, debounce counter and sticky latch
// for the external shutdown request.
//   clk, rst        clock, async active-high reset
//   pin_shutdown_i  asynchronous shutdown request
//   filter_i        debounce length (synced-high cycles before latching)
//   clr_i           clear request; honoured only while the synced input is low
//   sync_o          synchronised input
//   active_o        sticky shutdown state (registered)
module pincfg_shutdown_filter #(
  parameter int FILTER_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pin_shutdown_i,
  input  logic [FILTER_W-1:0] filter_i,
  input  logic                clr_i,
  output logic                sync_o,
  output logic                active_o
);
  logic                meta_q, sync_q, active_q;
  logic [FILTER_W-1:0] cnt_q;
  logic                set_c;

  // >= rather than == so that lowering FILTER below a running count
  // latches on the next high cycle instead of never.
  assign set_c = sync_q && (cnt_q >= filter_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      meta_q <= pin_shutdown_i;
      sync_q <= meta_q;
      if (!sync_q)                cnt_q <= '0;
      else if (cnt_q < filter_i)  cnt_q <= cnt_q + 1'b1;
      // set has priority over a simultaneous clear
      if (set_c)                  active_q <= 1'b1;
      else if (clr_i && !sync_q)  active_q <= 1'b0;
    end
  end

  assign sync_o   = sync_q;
  assign active_o = active_q;
endmodule

// File: rtl/pincfg_mux.sv
// pincfg_mux: per-pin source select + polarity with debounced sticky shutdown.
//   clk, rst         clock, async active-high reset
//   src_in           internal sources; select k picks src_in[k-1], 0 = const 0
//   pins_out         registered pin outputs
//   pin_shutdown     async shutdown request
//   shutdown_active  sticky shutdown state
//   wb               register bus (slave modport)
// Optional: PINCFG_MUX_EVENT_COUNT_EN adds EVCOUNT at address 5, a saturating
// count of shutdown activations; any write there clears it.
module pincfg_mux
  import pincfg_pkg::*;
#(
  parameter int NUM_PINS    = 8,
  parameter int NUM_SOURCES = 3,
  parameter int SEL_W       = 2,
  parameter int FILTER_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] src_in,
  output logic [NUM_PINS-1:0]    pins_out,
  input  logic                   pin_shutdown,
  output logic                   shutdown_active,
  pincfg_mux_if.slave            wb
);
  localparam int SEL_TOT = NUM_PINS * SEL_W;

  logic [NUM_PINS-1:0] pol_q, mask_q, pins_q, pin_d;
  logic [SEL_TOT-1:0]  sel_q;
  logic [FILTER_W-1:0] filt_q;
  logic                ack_q;
  logic [31:0]         dat_q, rd_c;
  logic                acc_c, wr_c, sync_c, sd_c;
  logic                unused_dat;

  // a held strobe is accepted only while ack is low -> ack every other cycle
  assign acc_c = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
  assign wr_c  = acc_c && wb.wb_we_i;
  assign unused_dat = ^wb.wb_dat_i;

  pincfg_shutdown_filter #(.FILTER_W(FILTER_W)) u_sd (
    .clk            (clk),
    .rst            (rst),
    .pin_shutdown_i (pin_shutdown),
    .filter_i       (filt_q),
    .clr_i          (wr_c && wb.wb_adr_i == ADR_STATUS && wb.wb_dat_i[ST_ACTIVE]),
    .sync_o         (sync_c),
    .active_o       (sd_c)
  );

`ifdef PINCFG_MUX_EVENT_COUNT_EN
  logic       sd_prev_q;
  logic [7:0] ev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_prev_q <= 1'b0;
      ev_q      <= '0;
    end else begin
      sd_prev_q <= sd_c;
      if (wr_c && wb.wb_adr_i == ADR_EVCOUNT)    ev_q <= '0;
      else if (sd_c && !sd_prev_q && ev_q != 8'hFF) ev_q <= ev_q + 8'd1;
    end
  end
`endif

  always_comb begin
    rd_c = '0;
    case (wb.wb_adr_i)
      ADR_POLARITY: rd_c[NUM_PINS-1:0] = pol_q;
      ADR_SELECT:   rd_c[SEL_TOT-1:0]  = sel_q;
      ADR_SDMASK:   rd_c[NUM_PINS-1:0] = mask_q;
      ADR_STATUS: begin
        rd_c[ST_ACTIVE] = sd_c;
        rd_c[ST_SYNC]   = sync_c;
      end
      ADR_FILTER:   rd_c[FILTER_W-1:0] = filt_q;
`ifdef PINCFG_MUX_EVENT_COUNT_EN
      ADR_EVCOUNT:  rd_c[7:0] = ev_q;
`endif
      default:      rd_c = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    logic [SEL_W-1:0] s;
    logic             src_b;
    assign s = sel_q[i*SEL_W +: SEL_W];
    // out-of-range selects fall through to constant 0
    always_comb begin
      src_b = 1'b0;
      for (int k = 0; k < NUM_SOURCES; k++)
        if (int'(s) == k + 1) src_b = src_in[k];
    end
    assign pin_d[i] = (sd_c && mask_q[i]) ? pol_q[i] : (src_b ^ pol_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol_q  <= '0;
      sel_q  <= '0;
      mask_q <= '0;
      filt_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      pins_q <= '0;
    end else begin
      ack_q  <= acc_c;
      pins_q <= pin_d;
      if (acc_c) dat_q <= wb.wb_we_i ? 32'd0 : rd_c;
      if (wr_c) begin
        case (wb.wb_adr_i)
          ADR_POLARITY: pol_q  <= wb.wb_dat_i[NUM_PINS-1:0];
          ADR_SELECT:   sel_q  <= wb.wb_dat_i[SEL_TOT-1:0];
          ADR_SDMASK:   mask_q <= wb.wb_dat_i[NUM_PINS-1:0];
          ADR_FILTER:   filt_q <= wb.wb_dat_i[FILTER_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign pins_out        = pins_q;
  assign shutdown_active = sd_c;
  assign wb.wb_ack_o     = ack_q;
  assign wb.wb_dat_o     = dat_q;
endmodule

// File: tb/tb_pincfg_mux.sv
// tb_pincfg_mux: directed stimulus; bus read data checked by a scoreboard
// monitor on each ack, pin/shutdown state checked at fixed edge offsets.
module tb_pincfg_mux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] src_in = '0;
  logic [7:0] pins_out;
  logic       pin_shutdown = 1'b0;
  logic       shutdown_active;

  pincfg_mux_if wb();

  pincfg_mux dut (
    .clk             (clk),
    .rst             (rst),
    .src_in          (src_in),
    .pins_out        (pins_out),
    .pin_shutdown    (pin_shutdown),
    .shutdown_active (shutdown_active),
    .wb              (wb.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one expected read word per acked request
  always @(negedge clk) begin
    if (wb.wb_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty: got ack with data 0x%0h expected no ack", wb.wb_dat_o);
      end else begin
        automatic logic [31:0] e = sb.pop_front();
        chk("rd_data", wb.wb_dat_o, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one request; ack must be present right after the first edge
  task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                     input logic [31:0] exp_rd);
    sb.push_back(we ? 32'd0 : exp_rd);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;
    tick(1);
    chk("ack_latency", {31'd0, wb.wb_ack_o}, 32'd1);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0; wb.wb_adr_i = 0; wb.wb_dat_i = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_pins", {24'd0, pins_out}, 32'h0);
    chk("rst_sd", {31'd0, shutdown_active}, 32'h0);
    chk("rst_ack", {31'd0, wb.wb_ack_o}, 32'h0);
    for (int a = 0; a < 6; a++) bus(1'b0, 4'(a), 32'h0, 32'h0);
    bus(1'b0, 4'd15, 32'h0, 32'h0);

    // polarity only, all selects constant 0
    bus(1'b1, 4'd0, 32'hA5, 0);
    bus(1'b1, 4'd1, 32'h0, 0);
    chk("pol_pins", {24'd0, pins_out}, 32'hA5);
    bus(1'b0, 4'd0, 32'h0, 32'hA5);
    bus(1'b1, 4'd7, 32'hFFFF, 0);       // unmapped write ignored
    bus(1'b0, 4'd7, 32'h0, 32'h0);

    // pin0 <- src[0], pin1 <- src[2] inverted
    bus(1'b1, 4'd1, 32'h0000_000D, 0);
    bus(1'b1, 4'd0, 32'h02, 0);
    bus(1'b0, 4'd1, 32'h0, 32'h0000_000D);
    src_in = 3'b101; tick(1);
    chk("src_101", {24'd0, pins_out}, 32'h01);
    src_in = 3'b000; tick(1);
    chk("src_000", {24'd0, pins_out}, 32'h02);
    src_in = 3'b100; tick(1);
    chk("src_100", {24'd0, pins_out}, 32'h00);

    // shutdown setup: every pin follows src[0]
    bus(1'b1, 4'd4, 32'd3, 0);
    bus(1'b1, 4'd2, 32'h0F, 0);
    bus(1'b1, 4'd0, 32'h00, 0);
    bus(1'b1, 4'd1, 32'h5555, 0);
    src_in = 3'b001; tick(1);
    chk("follow_all", {24'd0, pins_out}, 32'hFF);

    // 3-cycle glitch is below FILTER+1
    pin_shutdown = 1'b1; tick(3);
    pin_shutdown = 1'b0; tick(6);
    chk("glitch_sd", {31'd0, shutdown_active}, 32'h0);
    bus(1'b0, 4'd3, 32'h0, 32'h0);

    pin_shutdown = 1'b1; tick(5);
    chk("sd_edge5", {31'd0, shutdown_active}, 32'h0);
    tick(1);
    chk("sd_edge6", {31'd0, shutdown_active}, 32'h1);
    chk("pins_lag", {24'd0, pins_out}, 32'hFF);
    tick(1);
    chk("sd_pins", {24'd0, pins_out}, 32'hF0);
    src_in = 3'b000; tick(1);
    chk("sd_src0", {24'd0, pins_out}, 32'h00);
    src_in = 3'b001; tick(1);
    chk("sd_src1", {24'd0, pins_out}, 32'hF0);

    // clear ignored while input still high
    bus(1'b1, 4'd3, 32'h1, 0);
    chk("clr_ignored", {31'd0, shutdown_active}, 32'h1);
    bus(1'b0, 4'd3, 32'h0, 32'h3);
    pin_shutdown = 1'b0; tick(3);
    bus(1'b1, 4'd3, 32'h1, 0);
    chk("clr_done", {31'd0, shutdown_active}, 32'h0);
    bus(1'b0, 4'd3, 32'h0, 32'h0);
    chk("clr_pins", {24'd0, pins_out}, 32'hFF);

    // FILTER=0: latches three edges after the input rises
    bus(1'b1, 4'd4, 32'd0, 0);
    pin_shutdown = 1'b1; tick(2);
    chk("f0_edge2", {31'd0, shutdown_active}, 32'h0);
    tick(1);
    chk("f0_edge3", {31'd0, shutdown_active}, 32'h1);
    pin_shutdown = 1'b0; tick(3);
    bus(1'b1, 4'd3, 32'h1, 0);
    chk("f0_clr", {31'd0, shutdown_active}, 32'h0);

`ifdef PINCFG_MUX_EVENT_COUNT_EN
    bus(1'b0, 4'd5, 32'h0, 32'd2);
    for (int e = 0; e < 298; e++) begin
      pin_shutdown = 1'b1; tick(4);
      pin_shutdown = 1'b0; tick(3);
      bus(1'b1, 4'd3, 32'h1, 0);
    end
    bus(1'b0, 4'd5, 32'h0, 32'd255);
    bus(1'b1, 4'd5, 32'h0, 0);
    bus(1'b0, 4'd5, 32'h0, 32'd0);
`else
    bus(1'b1, 4'd5, 32'hFF, 0);
    bus(1'b0, 4'd5, 32'h0, 32'd0);
`endif

    // async reset mid-shutdown and mid-bus-cycle
    pin_shutdown = 1'b1; tick(4);
    chk("pre_rst_pins", {24'd0, pins_out}, 32'hF0);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 4'd3;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("arst_pins", {24'd0, pins_out}, 32'h0);
    chk("arst_sd", {31'd0, shutdown_active}, 32'h0);
    chk("arst_ack", {31'd0, wb.wb_ack_o}, 32'h0);
    chk("arst_dat", wb.wb_dat_o, 32'h0);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; pin_shutdown = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    bus(1'b0, 4'd1, 32'h0, 32'h0);
    tick(2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
